// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit arbiter.
//   NUM_REQ / ID_W : requester count and requester-index width
//   state_e        : arbiter FSM encoding (IDLE=0, HOLD=1)
//   FUNC_*         : common 2-input truth tables, bit index = {a,b}
//   rr_pick        : round-robin winner search
package lu_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Truth tables indexed by {a,b}: bit0 = a0b0, bit1 = a0b1, bit2 = a1b0, bit3 = a1b1.
    localparam logic [3:0] FUNC_AND  = 4'b1000;
    localparam logic [3:0] FUNC_OR   = 4'b1110;
    localparam logic [3:0] FUNC_XOR  = 4'b0110;
    localparam logic [3:0] FUNC_NAND = 4'b0111;

    // Search starts one above the previous winner and wraps. The loop walks
    // from the lowest priority (offset NUM_REQ, i.e. last itself) toward the
    // highest (offset 1), so the final hit is the highest-priority requester.
    // With no requester set the result is unused by the caller.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] win;
        win = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last + ID_W'(k);
            if (req[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/lu_arbiter_if.sv
// Signal bundle between the requesters/consumer and the arbiter.
//   master : requester + consumer side (drives req, a, b, func, out_ready)
//   slave  : arbiter side (drives gnt and the registered result)
interface lu_arbiter_if;
    import lu_pkg::*;

    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   a;
    logic [NUM_REQ-1:0]   b;
    logic [4*NUM_REQ-1:0] func;
    logic                 out_ready;
    logic [NUM_REQ-1:0]   gnt;
    logic                 out_valid;
    logic                 out;
    logic [ID_W-1:0]      out_id;
    logic [CNT_W-1:0]     op_cnt;

    modport master (
        output req, a, b, func, out_ready,
        input  gnt, out_valid, out, out_id, op_cnt
    );

    modport slave (
        input  req, a, b, func, out_ready,
        output gnt, out_valid, out, out_id, op_cnt
    );

endinterface

// File: rtl/lu_eval.sv
// 4:1 truth-table evaluator: out = func[{a,b}].
//   a, b : operand bits of the selected requester
//   func : 4-bit truth table of the selected requester
//   out  : evaluated result (combinational)
module lu_eval (
    input  logic       a,
    input  logic       b,
    input  logic [3:0] func,
    output logic       out
);

    assign out = func[{a, b}];

endmodule

// File: rtl/lu_arbiter.sv
// Round-robin arbiter in front of a single shared logic unit. One requester
// is granted per accepting cycle; its operands are evaluated and the result
// is held in an output register until the consumer takes it.
//   clk, rst       : clock, synchronous active-high reset
//   req/a/b/func   : per-requester request, operands and truth table
//   out_ready      : consumer takes the held result this cycle
//   gnt            : one-hot grant, combinational, high in the capture cycle
//   out_valid/out/out_id : registered result and owner
//   op_cnt         : completed-transfer counter, wraps
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | no result held; any request is granted
// HOLD  | result held (out_valid=1); grant only if out_ready
module lu_arbiter
    import lu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   a,
    input  logic [NUM_REQ-1:0]   b,
    input  logic [4*NUM_REQ-1:0] func,
    input  logic                 out_ready,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 out_valid,
    output logic                 out,
    output logic [ID_W-1:0]      out_id,
    output logic [CNT_W-1:0]     op_cnt
);

    state_e           state_q;
    logic             out_valid_q;
    logic             out_q;
    logic             out_d;
    logic [ID_W-1:0]  out_id_q;
    logic [ID_W-1:0]  last_id_q;
    logic [CNT_W-1:0] op_cnt_q;

    logic             accept;
    logic             grant;
    logic [ID_W-1:0]  win_id;
    logic             a_sel;
    logic             b_sel;
    logic [3:0]       func_sel;

    // A held result frees its slot in the same cycle it is taken, which is
    // what allows one grant per cycle under continuous demand.
    always_comb begin
        accept   = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
        grant    = !rst && accept && (req != '0);
        win_id   = rr_pick(req, last_id_q);
        gnt      = grant ? (NUM_REQ'(1) << win_id) : '0;
        a_sel    = a[win_id];
        b_sel    = b[win_id];
        func_sel = func[{win_id, 2'b00} +: 4];
    end

    lu_eval u_eval (
        .a    (a_sel),
        .b    (b_sel),
        .func (func_sel),
        .out  (out_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_q       <= 1'b0;
            out_id_q    <= '0;
            last_id_q   <= ID_W'(NUM_REQ - 1);
            op_cnt_q    <= '0;
        end else begin
            if (out_valid_q && out_ready) begin
                op_cnt_q <= op_cnt_q + CNT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (grant) begin
                        out_q       <= out_d;
                        out_id_q    <= win_id;
                        last_id_q   <= win_id;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (grant) begin
                        // back-to-back: old result leaves, new one captured
                        out_q       <= out_d;
                        out_id_q    <= win_id;
                        last_id_q   <= win_id;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_id    = out_id_q;
    assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_lu_arbiter.sv
// Directed bench for lu_arbiter: reset, single op, round-robin order,
// backpressure, operand isolation, mid-op reset and counter wrap.
module tb_lu_arbiter;
    import lu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lu_arbiter_if bus ();

    lu_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req),
        .a         (bus.a),
        .b         (bus.b),
        .func      (bus.func),
        .out_ready (bus.out_ready),
        .gnt       (bus.gnt),
        .out_valid (bus.out_valid),
        .out       (bus.out),
        .out_id    (bus.out_id),
        .op_cnt    (bus.op_cnt)
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic       rr_out [4];
    logic [3:0] exp_gnt;

    initial begin
        // requester results for the round-robin phase, a=1010 b=1100:
        // r0 AND(0,0)=0, r1 OR(1,0)=1, r2 NAND(0,1)=1, r3 XOR(1,1)=0
        rr_out[0] = 1'b0;
        rr_out[1] = 1'b1;
        rr_out[2] = 1'b1;
        rr_out[3] = 1'b0;

        // ---- reset held 2 cycles with all requests pending
        rst           = 1'b1;
        bus.req       = 4'hF;
        bus.a         = 4'h0;
        bus.b         = 4'h0;
        bus.func      = 16'h0000;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_op_cnt", 32'(bus.op_cnt), 32'h0);
        check("rst_out_id", 32'(bus.out_id), 32'h0);
        check("rst_out", 32'(bus.out), 32'h0);

        // ---- first grant after release goes to requester 0
        rst = 1'b0;
        #1;
        check("first_gnt", 32'(bus.gnt), 32'h1);
        tick();
        bus.req = 4'h0;
        #1;
        check("first_valid", 32'(bus.out_valid), 32'h1);
        check("first_id", 32'(bus.out_id), 32'h0);
        check("hold_gnt_zero", 32'(bus.gnt), 32'h0);
        bus.out_ready = 1'b1;
        tick();
        check("drain_valid", 32'(bus.out_valid), 32'h0);
        check("drain_cnt", 32'(bus.op_cnt), 32'h1);
        tick();
        check("idle_ready_cnt", 32'(bus.op_cnt), 32'h1);
        check("idle_ready_valid", 32'(bus.out_valid), 32'h0);

        // ---- single op: requester 2, a=1 b=0 XOR -> 1
        bus.req  = 4'b0100;
        bus.a    = 4'b0100;
        bus.b    = 4'b0000;
        bus.func = {4'h0, FUNC_XOR, 8'h00};
        #1;
        check("single_gnt", 32'(bus.gnt), 32'h4);
        tick();
        bus.req       = 4'h0;
        bus.out_ready = 1'b0;
        #1;
        check("single_valid", 32'(bus.out_valid), 32'h1);
        check("single_out", 32'(bus.out), 32'h1);
        check("single_id", 32'(bus.out_id), 32'h2);
        // operands change while held: result must not move
        bus.a    = 4'h0;
        bus.b    = 4'hF;
        bus.func = 16'h0000;
        tick();
        check("iso_out", 32'(bus.out), 32'h1);
        check("iso_id", 32'(bus.out_id), 32'h2);
        check("iso_valid", 32'(bus.out_valid), 32'h1);
        bus.out_ready = 1'b1;
        tick();
        check("single_drain_valid", 32'(bus.out_valid), 32'h0);
        check("single_drain_cnt", 32'(bus.op_cnt), 32'h2);

        // ---- reset again so priority restarts at requester 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_cnt", 32'(bus.op_cnt), 32'h0);

        // ---- round-robin with all requesting and consumer always ready
        bus.a    = 4'b1010;
        bus.b    = 4'b1100;
        bus.func = {FUNC_XOR, FUNC_NAND, FUNC_OR, FUNC_AND};
        bus.req  = 4'hF;
        bus.out_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            check("rr_gnt", 32'(bus.gnt), 32'(exp_gnt));
            if (k > 0) begin
                check("rr_id", 32'(bus.out_id), 32'(k - 1));
                check("rr_out", 32'(bus.out), 32'(rr_out[k - 1]));
                check("rr_cnt", 32'(bus.op_cnt), 32'(k - 1));
            end
            tick();
        end
        // now holding requester 0's result, op_cnt=4, last winner 0

        // ---- backpressure with requesters 0 and 1 pending
        bus.req       = 4'b0011;
        bus.out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("bp_gnt", 32'(bus.gnt), 32'h0);
            check("bp_id", 32'(bus.out_id), 32'h0);
            check("bp_out", 32'(bus.out), 32'h0);
            check("bp_valid", 32'(bus.out_valid), 32'h1);
            check("bp_cnt", 32'(bus.op_cnt), 32'h4);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_gnt", 32'(bus.gnt), 32'h2);
        tick();
        check("bp_next_id", 32'(bus.out_id), 32'h1);
        check("bp_next_out", 32'(bus.out), 32'h1);
        check("bp_next_cnt", 32'(bus.op_cnt), 32'h5);
        check("bp_wrap_gnt", 32'(bus.gnt), 32'h1);

        // ---- mid-op reset while holding with consumer stalled
        bus.out_ready = 1'b0;
        tick();
        check("pre_rst_id", 32'(bus.out_id), 32'h1);
        check("pre_rst_cnt", 32'(bus.op_cnt), 32'h5);
        rst = 1'b1;
        tick();
        check("midrst_valid", 32'(bus.out_valid), 32'h0);
        check("midrst_cnt", 32'(bus.op_cnt), 32'h0);
        check("midrst_id", 32'(bus.out_id), 32'h0);
        // idle with requests pending, yet reset must keep grants off
        check("midrst_gnt", 32'(bus.gnt), 32'h0);
        rst           = 1'b0;
        bus.req       = 4'h0;
        bus.out_ready = 1'b1;
        tick();
        check("lost_valid", 32'(bus.out_valid), 32'h0);
        check("lost_cnt", 32'(bus.op_cnt), 32'h0);

        // ---- counter wrap: first edge captures, each later edge completes one
        bus.req = 4'hF;
        repeat (256) tick();
        check("wrap_255", 32'(bus.op_cnt), 32'hFF);
        tick();
        check("wrap_0", 32'(bus.op_cnt), 32'h0);
        check("wrap_valid", 32'(bus.out_valid), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
